if_id_queue: RTL and testbench
==============================

# if_id_queue

Parametrised successor to the single-entry IF/ID latch: a DEPTH-entry instruction queue between IF and ID that decouples fetch from decode. Buffers {pc, inst} beats from IF, presents one registered instruction per cycle to ID, and squashes all buffered and in-flight fetches on a branch flush. A pending-drop flag generalises the old deferred-flush behaviour, so a fetch already in flight when the flush arrives is discarded on return.

## Interface
- ADDR_W, 32, pc width
- INST_W, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- STALL_W, 6, stall vector width
- IF_IDX, 1, stall bit owned by IF
- ID_IDX, 2, stall bit owned by ID
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- if_pc  in  ADDR_W  pc of fetched instruction
- if_inst  in  INST_W  fetched instruction
- if_valid  in  1  IF beat valid this cycle
- if_ready  out  1  queue can accept a beat; equals (count != DEPTH), driven from registers only
- id_pc  out  ADDR_W  registered pc to ID
- id_inst  out  INST_W  registered instruction to ID
- id_valid  out  1  id_pc/id_inst hold a real instruction
- count  out  $clog2(DEPTH)+1  queue occupancy, excluding the output register
- stall  in  STALL_W  pipeline stall vector
- ex_b_flag  in  1  branch taken resolved in EX
- id_b_flag  in  1  jump resolved in ID

## Operation
- flush = ex_b_flag | id_b_flag; advance = !stall[ID_IDX].
- Push: accept when if_valid & if_ready & !flush & !drop_pending. Write at wr_ptr; wr_ptr wraps modulo DEPTH.
- Output register on advance:
  - Load the head entry and set id_valid=1 when the queue is non-empty.
  - Otherwise load a bubble: id_pc=0, id_inst=0, id_valid=0.
- Output register when stalled: all three id_* outputs hold.
- Bypass (macro enabled): if the queue is empty, advance=1 and a beat is accepted, the beat goes straight to the output register. count is unchanged.
- Push and pop in the same cycle: count is unchanged and both pointers move.
- Flush, highest priority:
  - rd_ptr, wr_ptr and count are cleared to 0. Any same-cycle if_valid beat is discarded.
  - If advance=1, the output register becomes a bubble.
  - If stall[ID_IDX]=1, the output register holds; ID still owns the branch instruction.
- drop_pending:
  - Set when flush=1, stall[IF_IDX]=1 and if_valid=0, meaning a fetch is still outstanding.
  - While set, the next if_valid beat is discarded and the flag clears in that cycle.
  - A new flush while set keeps it set.
- If IF presents if_valid while if_ready=0, the beat is not accepted. IF must hold the beat.

## Timing
- Reset values: id_pc=0, id_inst=0, id_valid=0, count=0, pointers=0, drop_pending=0, if_ready=1.
- Reset is asynchronous: it clears mid-operation immediately, independent of clk.
- Latency IF->ID:
  - 1 cycle through bypass when the queue is empty.
  - Otherwise the beat becomes visible once it reaches the head, one cycle per preceding entry with ID advancing.
- Flush to empty queue: 1 cycle, so count=0 on the next edge.
- if_ready deasserts the cycle after count reaches DEPTH. Simultaneous pop when full does not raise if_ready in the same cycle, because if_ready is derived from registers only.
- Throughput: 1 instruction/cycle sustained when stall=0.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: empty-queue bypass is present and latency is 1 cycle, matching the legacy latch.
- Undefined: every beat is written to the queue first, minimum latency is 2 cycles, and no path exists from if_* to the output register.
- All other behaviour is identical in both builds.

## Test plan
- Stream: reset, stall=0, feed pc 0x00,0x04,0x08 on consecutive cycles -> id_pc 0x00,0x04,0x08 with id_valid=1 one cycle later each (bypass build), count stays 0.
- Fill: stall[ID_IDX]=1, push 4 beats -> count=4, if_ready=0, id_* held. A fifth if_valid beat is not accepted. Release the stall -> the 4 beats emerge in order and if_ready=1 after the first pop.
- Flush with ID stalled: queue count=3, id_pc=0x10, stall[ID_IDX]=1, ex_b_flag=1 -> next cycle count=0 and id_pc=0x10 is held. After the stall releases, id_valid=0.
- Deferred drop: stall[IF_IDX]=1, if_valid=0, id_b_flag=1 -> drop_pending=1. Next beat pc=0x20 is discarded and the following beat pc=0x40 reaches ID.
- Flush coincident with if_valid (pc=0x30) -> beat discarded, drop_pending stays 0, id_valid=0 next cycle.
- Async reset asserted mid-cycle with count=2 -> count=0, id_valid=0 and if_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry {pc, inst} queue between IF and ID with a
// registered output stage, branch flush and deferred drop of an in-flight fetch.
// Optional feature macro: IF_ID_QUEUE_BYPASS_EN enables the empty-queue bypass
// from the IF beat straight into the output register.
module if_id_queue #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 6,
  parameter int IF_IDX  = 1,
  parameter int ID_IDX  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         if_pc,
  input  logic [INST_W-1:0]         if_inst,
  input  logic                      if_valid,
  output logic                      if_ready,
  output logic [ADDR_W-1:0]         id_pc,
  output logic [INST_W-1:0]         id_inst,
  output logic                      id_valid,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      ex_b_flag,
  input  logic                      id_b_flag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              drop_pending_q, drop_pending_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic flush, advance, empty, accept, bypass, push, pop;

  // Only the IF and ID bits of the stall vector matter here; the rest are
  // folded into a deliberately unused signal.
  logic stall_unused;
  assign stall_unused = ^stall;

  assign flush    = ex_b_flag | id_b_flag;
  assign advance  = ~stall[ID_IDX];
  assign empty    = (count_q == '0);
  assign if_ready = (count_q != CNT_W'(DEPTH));
  assign accept   = if_valid & if_ready & ~flush & ~drop_pending_q;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass = accept & empty & advance;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept & ~bypass;
  assign pop  = advance & ~empty & ~flush;

  // Next-state for pointers, occupancy, drop flag and the output register.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    drop_pending_d = drop_pending_q;
    id_pc_d        = id_pc_q;
    id_inst_d      = id_inst_q;
    id_valid_d     = id_valid_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // A stalled ID still owns the branch instruction, so only bubble on advance.
      if (advance) begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (advance) begin
        if (!empty) begin
          id_pc_d    = pc_mem[rd_ptr_q];
          id_inst_d  = inst_mem[rd_ptr_q];
          id_valid_d = 1'b1;
        end else if (bypass) begin
          id_pc_d    = if_pc;
          id_inst_d  = if_inst;
          id_valid_d = 1'b1;
        end else begin
          id_pc_d    = '0;
          id_inst_d  = '0;
          id_valid_d = 1'b0;
        end
      end
    end

    // An outstanding fetch at flush time must be thrown away when it returns;
    // a flush arriving while already pending keeps the flag set.
    if (flush) begin
      drop_pending_d = drop_pending_q | (stall[IF_IDX] & ~if_valid);
    end else if (drop_pending_q && if_valid) begin
      drop_pending_d = 1'b0;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      drop_pending_q <= 1'b0;
      id_pc_q        <= '0;
      id_inst_q      <= '0;
      id_valid_q     <= 1'b0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      drop_pending_q <= drop_pending_d;
      id_pc_q        <= id_pc_d;
      id_inst_q      <= id_inst_d;
      id_valid_q     <= id_valid_d;
    end
  end

  // Queue storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count/pointers alone decide which entries are live.
    if (push) begin
      pc_mem[wr_ptr_q]   <= if_pc;
      inst_mem[wr_ptr_q] <= if_inst;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed self-checking bench for if_id_queue (DEPTH=4).
// Expectations follow the bypass or non-bypass build via IF_ID_QUEUE_BYPASS_EN.
module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [2:0]  count;
  logic [5:0]  stall;
  logic        ex_b_flag;
  logic        id_b_flag;

  int n_total;
  int n_pass;

  localparam logic [5:0] STALL_ID = 6'b000100;
  localparam logic [5:0] STALL_IF = 6'b000010;

  if_id_queue dut (
    .clk       (clk),
    .rst       (rst),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .count     (count),
    .stall     (stall),
    .ex_b_flag (ex_b_flag),
    .id_b_flag (id_b_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = pc ^ 32'hA500_0000;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    if_pc     = '0;
    if_inst   = '0;
    if_valid  = 1'b0;
    stall     = '0;
    ex_b_flag = 1'b0;
    id_b_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd1);
    check("rst_drop", 32'(dut.drop_pending_q), 32'd0);

    // Stream with stall=0
    for (int i = 0; i < 3; i++) begin
      beat(32'(4 * i));
      tick();
`ifdef IF_ID_QUEUE_BYPASS_EN
      check("stream_pc", id_pc, 32'(4 * i));
      check("stream_inst", id_inst, 32'(4 * i) ^ 32'hA500_0000);
      check("stream_valid", 32'(id_valid), 32'd1);
      check("stream_count", 32'(count), 32'd0);
`else
      check("stream_count", 32'(count), 32'd1);
      if (i > 0) begin
        check("stream_pc", id_pc, 32'(4 * (i - 1)));
        check("stream_valid", 32'(id_valid), 32'd1);
      end else begin
        check("stream_first_valid", 32'(id_valid), 32'd0);
      end
`endif
    end
    if_valid = 1'b0;
    tick();
`ifdef IF_ID_QUEUE_BYPASS_EN
    check("stream_drain_valid", 32'(id_valid), 32'd0);
`else
    check("stream_drain_pc", id_pc, 32'h8);
    check("stream_drain_valid", 32'(id_valid), 32'd1);
`endif
    tick();
    check("stream_bubble_valid", 32'(id_valid), 32'd0);
    check("stream_bubble_pc", id_pc, 32'd0);
    check("stream_end_count", 32'(count), 32'd0);

    // Fill to DEPTH with ID stalled
    stall = STALL_ID;
    for (int i = 0; i < 4; i++) begin
      beat(32'h100 + 32'(4 * i));
      tick();
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("fill_if_ready", 32'(if_ready), 32'd0);
    check("fill_id_valid_held", 32'(id_valid), 32'd0);
    beat(32'h110);
    tick();
    check("fill_fifth_count", 32'(count), 32'd4);
    if_valid = 1'b0;
    stall    = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("drain_pc", id_pc, 32'h100 + 32'(4 * i));
      check("drain_inst", id_inst, (32'h100 + 32'(4 * i)) ^ 32'hA500_0000);
      check("drain_valid", 32'(id_valid), 32'd1);
      check("drain_count", 32'(count), 32'(3 - i));
      check("drain_if_ready", 32'(if_ready), 32'd1);
    end
    tick();
    check("drain_bubble", 32'(id_valid), 32'd0);

    // Flush with ID stalled
    stall = STALL_ID;
    beat(32'h10);
    tick();
    stall = '0;
    beat(32'h14);
    tick();
    stall = STALL_ID;
    beat(32'h18);
    tick();
    beat(32'h1C);
    tick();
    check("fl_pre_count", 32'(count), 32'd3);
    check("fl_pre_pc", id_pc, 32'h10);
    if_valid  = 1'b0;
    ex_b_flag = 1'b1;
    tick();
    check("fl_count", 32'(count), 32'd0);
    check("fl_pc_held", id_pc, 32'h10);
    check("fl_valid_held", 32'(id_valid), 32'd1);
    check("fl_drop", 32'(dut.drop_pending_q), 32'd0);
    ex_b_flag = 1'b0;
    stall     = '0;
    tick();
    check("fl_release_valid", 32'(id_valid), 32'd0);
    check("fl_release_pc", id_pc, 32'd0);

    // Deferred drop of in-flight fetch
    stall     = STALL_IF;
    id_b_flag = 1'b1;
    tick();
    check("dd_set", 32'(dut.drop_pending_q), 32'd1);
    check("dd_bubble", 32'(id_valid), 32'd0);
    stall     = '0;
    id_b_flag = 1'b0;
    beat(32'h20);
    tick();
    check("dd_clear", 32'(dut.drop_pending_q), 32'd0);
    check("dd_drop_count", 32'(count), 32'd0);
    check("dd_drop_valid", 32'(id_valid), 32'd0);
    beat(32'h40);
    tick();
`ifdef IF_ID_QUEUE_BYPASS_EN
    check("dd_next_pc", id_pc, 32'h40);
    check("dd_next_valid", 32'(id_valid), 32'd1);
`else
    check("dd_next_count", 32'(count), 32'd1);
`endif
    if_valid = 1'b0;
    tick();
`ifndef IF_ID_QUEUE_BYPASS_EN
    check("dd_next_pc", id_pc, 32'h40);
    check("dd_next_valid", 32'(id_valid), 32'd1);
`endif
    tick();
    check("dd_end_valid", 32'(id_valid), 32'd0);

    // Flush coincident with a valid beat
    ex_b_flag = 1'b1;
    beat(32'h30);
    tick();
    check("fc_count", 32'(count), 32'd0);
    check("fc_valid", 32'(id_valid), 32'd0);
    check("fc_drop", 32'(dut.drop_pending_q), 32'd0);
    ex_b_flag = 1'b0;
    if_valid  = 1'b0;
    tick();
    check("fc_after_valid", 32'(id_valid), 32'd0);
    check("fc_after_count", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle
    stall = STALL_ID;
    for (int i = 0; i < 3; i++) begin
      beat(32'h50 + 32'(4 * i));
      tick();
    end
    if_valid = 1'b0;
    stall    = '0;
    tick();
    check("ar_pre_count", 32'(count), 32'd2);
    check("ar_pre_pc", id_pc, 32'h50);
    stall = STALL_ID;
    #3 rst = 1'b1;
    #1;
    check("ar_count", 32'(count), 32'd0);
    check("ar_valid", 32'(id_valid), 32'd0);
    check("ar_if_ready", 32'(if_ready), 32'd1);
    check("ar_pc", id_pc, 32'd0);
    #2 rst = 1'b0;
    stall = '0;
    tick();
    check("ar_post_valid", 32'(id_valid), 32'd0);
    check("ar_post_count", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
